// File: rtl/fu_issue_recv.sv
// fu_issue_recv: receive end of the RS-to-FU issue interface (two slots -> ALU0/ALU1/MULT/MEM).
// Build option: define FU_ISSUE_ONEHOT_CHK_EN to reject multi-hot grants (slot dropped, issue_err set).
package fu_issue_pkg;
  typedef enum logic [1:0] {
    NOP  = 2'd0,
    ALU  = 2'd1,
    MULT = 2'd2,
    MEM  = 2'd3
  } FUNC_UNIT;
endpackage

module fu_issue_recv
  import fu_issue_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int MULT_LAT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   gnt_bus,
  input  FUNC_UNIT [1:0]       func_in,
  input  logic                 alu0_ready,
  input  logic                 alu1_ready,
  input  logic                 mem_ready,
  output logic                 alu0_valid,
  output logic                 alu1_valid,
  output logic                 mem_valid,
  output logic [IDX_W-1:0]     alu0_idx,
  output logic [IDX_W-1:0]     alu1_idx,
  output logic [IDX_W-1:0]     mem_idx,
  output logic                 mult_done_valid,
  output logic [IDX_W-1:0]     mult_done_idx,
  output logic                 ALU0_stall_out,
  output logic                 ALU1_stall_out,
  output logic                 mem_stall,
  output logic                 issue_err
);

  // Lowest set bit wins, so a multi-hot grant encodes deterministically.
  function automatic logic [IDX_W-1:0] f_lowest(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic [1:0]        r_alu_v;
  logic [IDX_W-1:0]  r_alu_idx [2];
  logic              r_mem_v;
  logic [IDX_W-1:0]  r_mem_idx;
  logic              r_mult_v   [MULT_LAT];
  logic [IDX_W-1:0]  r_mult_idx [MULT_LAT];
  logic              r_err;

  logic [WIDTH-1:0]  w_gnt [2];
  FUNC_UNIT          w_func [2];
  logic [IDX_W-1:0]  w_idx [2];
  logic [1:0]        w_act;
  logic [1:0]        w_ok;
  logic [1:0]        w_use;
  logic [1:0]        w_err_nognt;
  logic [1:0]        w_err_mh;
  logic              w_overlap;

  logic [1:0]        w_alu_rdy;
  logic [1:0]        w_free;
  logic              w_mem_stall;

  logic [1:0]        w_avail;
  logic [1:0]        w_alu_ld;
  logic [IDX_W-1:0]  w_alu_ld_idx [2];
  logic              w_mult_ld;
  logic [IDX_W-1:0]  w_mult_ld_idx;
  logic              w_mem_ld;
  logic [IDX_W-1:0]  w_mem_ld_idx;
  logic              w_mult_seen;
  logic              w_mem_seen;
  logic              w_err_set;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign w_gnt[s]       = gnt_bus[s*WIDTH +: WIDTH];
    assign w_func[s]      = func_in[s];
    assign w_idx[s]       = f_lowest(w_gnt[s]);
    assign w_act[s]       = (|w_gnt[s]) & (w_func[s] != NOP);
    assign w_err_nognt[s] = (w_func[s] != NOP) & ~(|w_gnt[s]);
`ifdef FU_ISSUE_ONEHOT_CHK_EN
    assign w_ok[s]        = ((w_gnt[s] & (w_gnt[s] - WIDTH'(1))) == '0);
`else
    assign w_ok[s]        = 1'b1;
`endif
    assign w_use[s]       = w_act[s] & w_ok[s];
    assign w_err_mh[s]    = w_act[s] & ~w_ok[s];
  end

  assign w_overlap   = |(w_gnt[0] & w_gnt[1]);
  assign w_alu_rdy   = {alu1_ready, alu0_ready};
  assign w_free      = ~r_alu_v | w_alu_rdy;
  assign w_mem_stall = r_mem_v & ~mem_ready;

  // Slot0 is routed first; w_avail tracks which ALUs remain for slot1.
  always_comb begin
    w_avail         = w_free;
    w_alu_ld        = '0;
    w_alu_ld_idx[0] = '0;
    w_alu_ld_idx[1] = '0;
    w_mult_ld       = 1'b0;
    w_mult_ld_idx   = '0;
    w_mem_ld        = 1'b0;
    w_mem_ld_idx    = '0;
    w_mult_seen     = 1'b0;
    w_mem_seen      = 1'b0;
    w_err_set       = w_overlap;
    for (int s = 0; s < 2; s++) begin
      if (w_err_nognt[s] || w_err_mh[s]) w_err_set = 1'b1;
      if (w_use[s]) begin
        case (w_func[s])
          ALU: begin
            if (w_avail[0]) begin
              w_alu_ld[0]     = 1'b1;
              w_alu_ld_idx[0] = w_idx[s];
              w_avail[0]      = 1'b0;
            end else if (w_avail[1]) begin
              w_alu_ld[1]     = 1'b1;
              w_alu_ld_idx[1] = w_idx[s];
              w_avail[1]      = 1'b0;
            end else begin
              w_err_set = 1'b1;
            end
          end
          MULT: begin
            if (w_mult_seen) begin
              w_err_set = 1'b1;
            end else begin
              w_mult_ld     = 1'b1;
              w_mult_ld_idx = w_idx[s];
            end
            w_mult_seen = 1'b1;
          end
          MEM: begin
            if (w_mem_seen || w_mem_stall) begin
              w_err_set = 1'b1;
            end else begin
              w_mem_ld     = 1'b1;
              w_mem_ld_idx = w_idx[s];
            end
            w_mem_seen = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_alu_v      <= '0;
      r_alu_idx[0] <= '0;
      r_alu_idx[1] <= '0;
      r_mem_v      <= 1'b0;
      r_mem_idx    <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < MULT_LAT; i++) begin
        r_mult_v[i]   <= 1'b0;
        r_mult_idx[i] <= '0;
      end
    end else begin
      // Load wins over drain so a draining ALU can be refilled in the same cycle.
      for (int k = 0; k < 2; k++) begin
        if (w_alu_ld[k]) begin
          r_alu_v[k]   <= 1'b1;
          r_alu_idx[k] <= w_alu_ld_idx[k];
        end else if (w_alu_rdy[k]) begin
          r_alu_v[k]   <= 1'b0;
        end
      end
      if (w_mem_ld) begin
        r_mem_v   <= 1'b1;
        r_mem_idx <= w_mem_ld_idx;
      end else if (mem_ready) begin
        r_mem_v   <= 1'b0;
      end
      r_mult_v[0]   <= w_mult_ld;
      r_mult_idx[0] <= w_mult_ld_idx;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_mult_v[i]   <= r_mult_v[i-1];
        r_mult_idx[i] <= r_mult_idx[i-1];
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign alu0_valid      = r_alu_v[0];
  assign alu1_valid      = r_alu_v[1];
  assign alu0_idx        = r_alu_idx[0];
  assign alu1_idx        = r_alu_idx[1];
  assign mem_valid       = r_mem_v;
  assign mem_idx         = r_mem_idx;
  assign mult_done_valid = r_mult_v[MULT_LAT-1];
  assign mult_done_idx   = r_mult_idx[MULT_LAT-1];
  assign ALU0_stall_out  = ~w_free[0] & ~w_free[1];
  assign ALU1_stall_out  = ~w_free[0] | ~w_free[1];
  assign mem_stall       = w_mem_stall;
  assign issue_err       = r_err;

endmodule

// File: tb/tb_fu_issue_recv.sv
// Testbench for fu_issue_recv: directed vector table, multi-cycle sequences and random traffic vs. a queue-based model.
module tb_fu_issue_recv;
  import fu_issue_pkg::*;

  localparam int WIDTH    = 16;
  localparam int IDX_W    = 4;
  localparam int MULT_LAT = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [2*WIDTH-1:0] gnt_bus;
  FUNC_UNIT [1:0]     func_in;
  logic               alu0_ready, alu1_ready, mem_ready;
  logic               alu0_valid, alu1_valid, mem_valid;
  logic [IDX_W-1:0]   alu0_idx, alu1_idx, mem_idx;
  logic               mult_done_valid;
  logic [IDX_W-1:0]   mult_done_idx;
  logic               ALU0_stall_out, ALU1_stall_out, mem_stall, issue_err;

  always #5 clock = ~clock;

  fu_issue_recv #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MULT_LAT(MULT_LAT)) dut (
    .clock(clock), .reset(reset), .gnt_bus(gnt_bus), .func_in(func_in),
    .alu0_ready(alu0_ready), .alu1_ready(alu1_ready), .mem_ready(mem_ready),
    .alu0_valid(alu0_valid), .alu1_valid(alu1_valid), .mem_valid(mem_valid),
    .alu0_idx(alu0_idx), .alu1_idx(alu1_idx), .mem_idx(mem_idx),
    .mult_done_valid(mult_done_valid), .mult_done_idx(mult_done_idx),
    .ALU0_stall_out(ALU0_stall_out), .ALU1_stall_out(ALU1_stall_out),
    .mem_stall(mem_stall), .issue_err(issue_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: held ops per unit, multiplies as a queue of (due edge, idx).
  typedef struct { int due; logic [IDX_W-1:0] idx; } mq_t;
  logic             m_alu_v [2];
  logic [IDX_W-1:0] m_alu_i [2];
  logic             m_mem_v;
  logic [IDX_W-1:0] m_mem_i;
  logic             m_err;
  mq_t              mq [$];
  int               m_edge = 0;
  logic             e_done;
  logic [IDX_W-1:0] e_done_idx;
  logic             cap_s0, cap_s1, cap_ms;

  task automatic model_reset();
    m_alu_v[0] = 1'b0; m_alu_v[1] = 1'b0;
    m_alu_i[0] = '0;   m_alu_i[1] = '0;
    m_mem_v = 1'b0; m_mem_i = '0; m_err = 1'b0;
    mq.delete();
    e_done = 1'b0; e_done_idx = '0;
  endtask

  task automatic model_step();
    logic [WIDTH-1:0] g [2];
    FUNC_UNIT         f [2];
    logic             rdy [2];
    logic             fr [2];
    logic             stall_m, mult_seen, mem_seen, placed;
    logic [IDX_W-1:0] idx;
    m_edge++;
    if (!reset) begin
      model_reset();
      return;
    end
    g[0] = gnt_bus[WIDTH-1:0];
    g[1] = gnt_bus[2*WIDTH-1:WIDTH];
    f[0] = func_in[0];
    f[1] = func_in[1];
    rdy[0] = alu0_ready;
    rdy[1] = alu1_ready;
    stall_m = m_mem_v && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      fr[k] = !m_alu_v[k] || rdy[k];
      if (rdy[k]) m_alu_v[k] = 1'b0;
    end
    if (mem_ready) m_mem_v = 1'b0;
    if ((g[0] & g[1]) != 0) m_err = 1'b1;
    mult_seen = 1'b0;
    mem_seen  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (f[s] == NOP) continue;
      if (g[s] == 0) begin m_err = 1'b1; continue; end
`ifdef FU_ISSUE_ONEHOT_CHK_EN
      if ($countones(g[s]) > 1) begin m_err = 1'b1; continue; end
`endif
      idx = '0;
      for (int b = 0; b < WIDTH; b++) begin
        if (g[s][b]) begin idx = IDX_W'(b); break; end
      end
      case (f[s])
        ALU: begin
          placed = 1'b0;
          for (int k = 0; k < 2; k++) begin
            if (!placed && fr[k]) begin
              m_alu_v[k] = 1'b1; m_alu_i[k] = idx; fr[k] = 1'b0; placed = 1'b1;
            end
          end
          if (!placed) m_err = 1'b1;
        end
        MULT: begin
          if (mult_seen) m_err = 1'b1;
          else mq.push_back('{due: m_edge + MULT_LAT - 1, idx: idx});
          mult_seen = 1'b1;
        end
        MEM: begin
          if (mem_seen || stall_m) m_err = 1'b1;
          else begin m_mem_v = 1'b1; m_mem_i = idx; end
          mem_seen = 1'b1;
        end
        default: ;
      endcase
    end
    e_done = 1'b0;
    if (mq.size() > 0 && mq[0].due == m_edge) begin
      e_done = 1'b1;
      e_done_idx = mq[0].idx;
      void'(mq.pop_front());
    end
  endtask

  // One clock: combinational checks at negedge, registered checks 1 time unit after posedge.
  task automatic tick();
    logic f0, f1;
    @(negedge clock);
    f0 = !m_alu_v[0] || alu0_ready;
    f1 = !m_alu_v[1] || alu1_ready;
    cap_s0 = ALU0_stall_out;
    cap_s1 = ALU1_stall_out;
    cap_ms = mem_stall;
    chk("alu0_stall", ALU0_stall_out, !f0 && !f1);
    chk("alu1_stall", ALU1_stall_out, !f0 || !f1);
    chk("mem_stall", mem_stall, m_mem_v && !mem_ready);
    @(posedge clock);
    model_step();
    #1;
    chk("alu0_valid", alu0_valid, m_alu_v[0]);
    chk("alu1_valid", alu1_valid, m_alu_v[1]);
    chk("mem_valid", mem_valid, m_mem_v);
    chk("issue_err", issue_err, m_err);
    chk("mult_done_valid", mult_done_valid, e_done);
    if (m_alu_v[0]) chk("alu0_idx", alu0_idx, m_alu_i[0]);
    if (m_alu_v[1]) chk("alu1_idx", alu1_idx, m_alu_i[1]);
    if (m_mem_v)    chk("mem_idx", mem_idx, m_mem_i);
    if (e_done)     chk("mult_done_idx", mult_done_idx, e_done_idx);
  endtask

  task automatic idle();
    gnt_bus = '0;
    func_in[0] = NOP;
    func_in[1] = NOP;
    alu0_ready = 1'b0; alu1_ready = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_gnt();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return '0;
    if (r < 8) return WIDTH'(1) << $urandom_range(0, WIDTH-1);
    return WIDTH'($urandom);
  endfunction

  typedef struct {
    logic [WIDTH-1:0] g0, g1;
    FUNC_UNIT         f0, f1;
    logic             r0, r1, rm;
    logic             s0, s1, ms;
    logic             a0v; logic [IDX_W-1:0] a0i;
    logic             a1v; logic [IDX_W-1:0] a1i;
    logic             mv;  logic [IDX_W-1:0] mi;
    logic             err;
  } vec_t;

  vec_t vt [7];

  initial begin
    int cnt, first_k;
    logic [WIDTH-1:0] g0r, g1r;

    vt[0] = '{16'h0004, 16'h0100, ALU, ALU, 0,0,0, 0,0,0, 1,4'd2, 1,4'd8, 0,4'd0, 0};
    vt[1] = '{16'h0000, 16'h0000, NOP, NOP, 0,0,0, 1,1,0, 1,4'd2, 1,4'd8, 0,4'd0, 0};
    vt[2] = '{16'h0000, 16'h0000, NOP, NOP, 0,1,0, 0,1,0, 1,4'd2, 0,4'd0, 0,4'd0, 0};
    vt[3] = '{16'h0020, 16'h0000, ALU, NOP, 1,0,0, 0,0,0, 1,4'd5, 0,4'd0, 0,4'd0, 0};
    vt[4] = '{16'h0002, 16'h0000, MEM, NOP, 1,0,0, 0,0,0, 0,4'd0, 0,4'd0, 1,4'd1, 0};
    vt[5] = '{16'h0000, 16'h0004, NOP, MEM, 0,0,0, 0,0,1, 0,4'd0, 0,4'd0, 1,4'd1, 1};
    vt[6] = '{16'h0000, 16'h0000, NOP, NOP, 0,0,1, 0,0,0, 0,4'd0, 0,4'd0, 0,4'd0, 1};

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();
    #1;
    reset = 1'b1;

    repeat (10) tick();
    chk("idle_outputs", {alu0_valid, alu1_valid, mem_valid, mult_done_valid, issue_err,
                         ALU0_stall_out, ALU1_stall_out, mem_stall}, 0);

    for (int i = 0; i < 7; i++) begin
      gnt_bus    = {vt[i].g1, vt[i].g0};
      func_in[0] = vt[i].f0;
      func_in[1] = vt[i].f1;
      alu0_ready = vt[i].r0;
      alu1_ready = vt[i].r1;
      mem_ready  = vt[i].rm;
      tick();
      chk($sformatf("vec%0d_alu0_stall", i), cap_s0, vt[i].s0);
      chk($sformatf("vec%0d_alu1_stall", i), cap_s1, vt[i].s1);
      chk($sformatf("vec%0d_mem_stall", i), cap_ms, vt[i].ms);
      chk($sformatf("vec%0d_alu0_valid", i), alu0_valid, vt[i].a0v);
      chk($sformatf("vec%0d_alu1_valid", i), alu1_valid, vt[i].a1v);
      chk($sformatf("vec%0d_mem_valid", i), mem_valid, vt[i].mv);
      chk($sformatf("vec%0d_issue_err", i), issue_err, vt[i].err);
      if (vt[i].a0v) chk($sformatf("vec%0d_alu0_idx", i), alu0_idx, vt[i].a0i);
      if (vt[i].a1v) chk($sformatf("vec%0d_alu1_idx", i), alu1_idx, vt[i].a1i);
      if (vt[i].mv)  chk($sformatf("vec%0d_mem_idx", i), mem_idx, vt[i].mi);
    end
    idle();
    repeat (3) tick();
    chk("err_sticky", issue_err, 1);

    // MULT latency: done exactly MULT_LAT edges after the sampling edge.
    do_reset();
    gnt_bus = {16'h0000, 16'h8000};
    func_in[0] = MULT;
    tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      chk($sformatf("mult_lat_k%0d", k), mult_done_valid, k == MULT_LAT);
      if (k == MULT_LAT) chk("mult_lat_idx", mult_done_idx, 15);
    end

    // Back-to-back MULTs give consecutive pulses.
    cnt = 0;
    first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 3) begin
        gnt_bus = {16'h0000, WIDTH'(1) << (k - 1)};
        func_in[0] = MULT;
      end else begin
        idle();
      end
      tick();
      if (mult_done_valid === 1'b1) begin
        if (cnt == 0) first_k = k;
        chk($sformatf("b2b_idx%0d", cnt), mult_done_idx, cnt);
        cnt++;
      end
    end
    chk("b2b_count", cnt, 3);
    chk("b2b_first", first_k, MULT_LAT);

    // Two MULTs in one cycle: slot1 dropped.
    gnt_bus = {16'h0002, 16'h0001};
    func_in[0] = MULT;
    func_in[1] = MULT;
    tick();
    idle();
    chk("dual_mult_err", issue_err, 1);
    cnt = 0;
    repeat (6) begin
      tick();
      if (mult_done_valid === 1'b1) cnt++;
    end
    chk("dual_mult_pulses", cnt, 1);

    // Reset mid-flight flushes in-flight multiplies.
    do_reset();
    gnt_bus = {16'h0000, 16'h0010};
    func_in[0] = MULT;
    tick();
    idle();
    tick();
    do_reset();
    cnt = 0;
    repeat (6) begin
      tick();
      if (mult_done_valid === 1'b1) cnt++;
    end
    chk("flush_mult_pulses", cnt, 0);

    // ALU slot with no free ALU is dropped.
    gnt_bus = {16'h0200, 16'h0001};
    func_in[0] = ALU;
    func_in[1] = ALU;
    tick();
    gnt_bus = {16'h0000, 16'h0040};
    func_in[1] = NOP;
    tick();
    chk("alu_drop_err", issue_err, 1);
    chk("alu_drop_idx0", alu0_idx, 0);
    chk("alu_drop_idx1", alu1_idx, 9);

    // Func set but no grant.
    do_reset();
    gnt_bus = '0;
    func_in[1] = ALU;
    tick();
    idle();
    chk("nognt_err", issue_err, 1);

    // Overlapping grants.
    do_reset();
    gnt_bus = {16'h0010, 16'h0010};
    func_in[0] = ALU;
    func_in[1] = MULT;
    tick();
    idle();
    chk("overlap_err", issue_err, 1);

    // Multi-hot grant.
    do_reset();
    gnt_bus = {16'h0000, 16'h0003};
    func_in[0] = ALU;
    tick();
    idle();
`ifdef FU_ISSUE_ONEHOT_CHK_EN
    chk("multihot_err", issue_err, 1);
    chk("multihot_alu0_valid", alu0_valid, 0);
`else
    chk("multihot_err", issue_err, 0);
    chk("multihot_alu0_valid", alu0_valid, 1);
    chk("multihot_alu0_idx", alu0_idx, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      g0r = rnd_gnt();
      g1r = ($urandom_range(0, 7) == 0) ? g0r : rnd_gnt();
      gnt_bus    = {g1r, g0r};
      func_in[0] = FUNC_UNIT'($urandom_range(0, 3));
      func_in[1] = FUNC_UNIT'($urandom_range(0, 3));
      alu0_ready = 1'($urandom_range(0, 1));
      alu1_ready = 1'($urandom_range(0, 1));
      mem_ready  = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    idle();
    repeat (MULT_LAT + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_issue_recv.md
Name: fu_issue_recv

Overview:
- Receive end of the RS-to-FU issue interface.
- Each cycle it accepts up to two issue slots (one-hot grant vector plus FUNC_UNIT tag per slot) and routes each grant to ALU0, ALU1, the pipelined multiplier or the memory port.
- It holds each grant in a per-FU register until that FU's ready/ack handshake completes.
- It generates the ALU stall pair consumed by the issue selector, and MEM/error status.

Parameters:
- WIDTH, 16, number of RS entries; width of each grant vector.
- IDX_W, $clog2(WIDTH), width of an encoded RS index.
- MULT_LAT, 4, multiplier pipeline depth in cycles (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- gnt_bus  in  2*WIDTH  slot0 = [WIDTH-1:0], slot1 = [2*WIDTH-1:WIDTH]; each slot is one-hot or zero
- func_in  in  FUNC_UNIT[1:0]  per-slot FU tag (ALU/MULT/MEM/NOP)
- alu0_ready, alu1_ready  in  1  ALU consumes its held op this cycle
- mem_ready  in  1  memory port consumes its held op this cycle
- alu0_valid, alu1_valid, mem_valid  out  1  holding register full
- alu0_idx, alu1_idx, mem_idx  out  IDX_W  RS index held
- mult_done_valid  out  1  multiply completes
- mult_done_idx  out  IDX_W  RS index of completing multiply
- ALU0_stall_out  out  1  no ALU can take an op this cycle
- ALU1_stall_out  out  1  at most one ALU can take an op this cycle
- mem_stall  out  1  MEM register full and not draining
- issue_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset==0 at posedge):
  - All *_valid, mult pipeline valids and issue_err clear to 0.
  - Index outputs clear to 0.
  - Stalls evaluate to 0.
- Index encode: slot one-hot -> binary index of the set bit.
- Slot active: gnt non-zero AND func != NOP.
- ALU free_k: !aluk_valid | aluk_ready (combinational; drain and refill in the same cycle is allowed).
- Stall outputs (combinational from current state and ready inputs):
  - ALU0_stall_out = !free_0 & !free_1.
  - ALU1_stall_out = !free_0 | !free_1.
  - The combination ALU0=1, ALU1=0 is never driven.
- ALU routing, slot0 before slot1:
  - Each active ALU slot takes the lowest-numbered free ALU.
  - An ALU slot with no free ALU is dropped and sets issue_err.
  - Effects are visible at the next edge.
- aluk_valid next state:
  - Set when loaded.
  - Else cleared when aluk_ready.
  - Else held.
  - Load wins over drain.
- MULT:
  - A MULT_LAT-stage shift register of {valid, idx}; always accepts.
  - An op issued at edge t produces mult_done_valid=1 during cycle t+MULT_LAT.
  - Both slots MULT in the same cycle: slot0 accepted, slot1 dropped, issue_err set.
- MEM:
  - Single holding register; mem_stall = mem_valid & !mem_ready.
  - Issue while mem_stall: op dropped, issue_err set.
  - Both slots MEM: slot0 accepted, slot1 dropped, issue_err set.
- Protocol errors that also set issue_err:
  - Slot with func != NOP and gnt == 0.
  - Slot0 and slot1 grants overlapping (bitwise AND non-zero).
- issue_err clears only on reset.
- ready inputs while the matching *_valid==0 are ignored.
- Reset mid-operation flushes all held ops and in-flight multiplies; no mult_done_valid is issued for them.

Optional Feature:
- Macro: FU_ISSUE_ONEHOT_CHK_EN.
- When defined:
  - Each active slot's gnt is checked for exactly one set bit (x & (x-1) == 0).
  - A multi-hot grant sets issue_err, and that slot is dropped.
- When undefined: no check; a multi-hot grant encodes to its lowest set bit and issue_err is not affected by it.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> all valids 0, stalls 0, issue_err 0, mult_done_valid 0 for 10 cycles.
- Dual ALU issue: slot0 gnt=0x0004 ALU, slot1 gnt=0x0100 ALU, readys=0 -> next cycle alu0_idx=2, alu1_idx=8, both valid, ALU0_stall_out=1, ALU1_stall_out=1. Raise alu1_ready -> ALU1_stall_out=1, ALU0_stall_out=0.
- Drain+refill: ALU0 full with idx 3, alu0_ready=1, slot0 ALU gnt=0x0020 in the same cycle -> alu0_valid stays 1, alu0_idx=5, no issue_err.
- MULT latency: MULT issued with gnt=0x8000 at edge t -> mult_done_valid=1, mult_done_idx=15 exactly at cycle t+4 (MULT_LAT=4), 0 at t+3 and t+5. Back-to-back MULTs on 3 cycles -> 3 consecutive done pulses.
- MEM overflow: mem_valid=1 idx 1, mem_ready=0, new MEM issue gnt=0x0002<<1 -> mem_idx stays 1, issue_err=1 and remains 1 until reset.
- Protocol: slot1 func=ALU, gnt=0 -> issue_err=1. With FU_ISSUE_ONEHOT_CHK_EN defined, gnt=0x0003 ALU -> issue_err=1, alu0_valid=0. Without the macro, same stimulus -> alu0_idx=0, issue_err=0.
